// File: rtl/rom_port_arb.sv
// ROM port arbiter: shares one single-port ROM RAM between CPU reads, video reads and the ROM download.
// Optional download checksum accumulator is enabled by defining ROM_PORT_ARB_CKSUM_EN.
module rom_port_arb #(
    parameter int              AW       = 17,
    parameter logic [AW-1:0]   VID_BASE = AW'(17'h10000),
    parameter int              HOLD     = 16
) (
    input  logic          MCLK,
    input  logic          RESET,
    input  logic          DL_ACT,
    input  logic          DL_WR,
    input  logic [AW-1:0] DL_AD,
    input  logic [7:0]    DL_DT,
    input  logic          CPU_REQ,
    input  logic [15:0]   CPU_AD,
    output logic          CPU_ACK,
    output logic [7:0]    CPU_DT,
    input  logic          VID_REQ,
    input  logic [15:0]   VID_AD,
    output logic          VID_ACK,
    output logic [7:0]    VID_DT,
    output logic [AW-1:0] MEM_AD,
    output logic          MEM_WE,
    output logic [7:0]    MEM_DI,
    input  logic [7:0]    MEM_DO,
    output logic          CORE_RST,
    output logic [15:0]   CKSUM
);

    // state   | meaning
    // IDLE    | no access in flight; may grant one read
    // GNT_CPU | CPU address on MEM_AD, data returns next cycle
    // GNT_VID | video address on MEM_AD, data returns next cycle
    // LOAD    | download owns the RAM write port
    // POST    | core held in reset while hold counter runs down
    typedef enum logic [2:0] {IDLE, GNT_CPU, GNT_VID, LOAD, POST} state_t;

    localparam logic [7:0] HOLD_CNT = 8'(HOLD);

    state_t        state_q;
    logic [7:0]    hold_q;
    logic          cpu_ack_q;
    logic          vid_ack_q;
    logic          last_vid_q;
    logic [AW-1:0] rd_ad_q;
    logic [7:0]    cpu_dt_q;
    logic [7:0]    vid_dt_q;

    logic          cpu_pend_d;
    logic          vid_pend_d;
    logic          pick_vid_d;

    // A requester still sees its REQ high during its ACK cycle; that is not a new request.
    assign cpu_pend_d = CPU_REQ && !cpu_ack_q;
    assign vid_pend_d = VID_REQ && !vid_ack_q;
    assign pick_vid_d = vid_pend_d && (!cpu_pend_d || !last_vid_q);

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q    <= POST;
            hold_q     <= HOLD_CNT;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            last_vid_q <= 1'b1;
            rd_ad_q    <= '0;
            cpu_dt_q   <= 8'h00;
            vid_dt_q   <= 8'h00;
        end else begin
            // An issued grant always completes, even when the download takes over.
            cpu_ack_q <= (state_q == GNT_CPU);
            vid_ack_q <= (state_q == GNT_VID);
            if (cpu_ack_q) cpu_dt_q <= MEM_DO;
            if (vid_ack_q) vid_dt_q <= MEM_DO;

            if (DL_ACT) begin
                if (state_q == POST) hold_q <= HOLD_CNT;
                state_q <= LOAD;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cpu_pend_d || vid_pend_d) begin
                            state_q    <= pick_vid_d ? GNT_VID : GNT_CPU;
                            last_vid_q <= pick_vid_d;
                            rd_ad_q    <= pick_vid_d ? VID_BASE + AW'(VID_AD) : AW'(CPU_AD);
                        end
                    end
                    GNT_CPU, GNT_VID: state_q <= IDLE;
                    LOAD: begin
                        state_q <= POST;
                        hold_q  <= HOLD_CNT;
                    end
                    POST: begin
                        if (hold_q <= 8'd1) begin
                            state_q <= IDLE;
                            hold_q  <= 8'd0;
                        end else begin
                            hold_q <= hold_q - 8'd1;
                        end
                    end
                    default: state_q <= POST;
                endcase
            end
        end
    end

    assign MEM_WE   = !RESET && (state_q == LOAD) && DL_ACT && DL_WR;
    assign MEM_AD   = RESET ? '0 : ((state_q == LOAD) ? DL_AD : rd_ad_q);
    assign MEM_DI   = (RESET || state_q != LOAD) ? 8'h00 : DL_DT;
    assign CPU_ACK  = cpu_ack_q && !RESET;
    assign VID_ACK  = vid_ack_q && !RESET;
    assign CPU_DT   = RESET ? 8'h00 : (cpu_ack_q ? MEM_DO : cpu_dt_q);
    assign VID_DT   = RESET ? 8'h00 : (vid_ack_q ? MEM_DO : vid_dt_q);
    assign CORE_RST = RESET || (state_q == LOAD) || (state_q == POST);

`ifdef ROM_PORT_ARB_CKSUM_EN
    logic [15:0] cksum_q;

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            cksum_q <= 16'h0000;
        end else if (DL_ACT && state_q != LOAD) begin
            cksum_q <= 16'h0000;
        end else if (MEM_WE) begin
            cksum_q <= cksum_q + {8'h00, DL_DT};
        end
    end

    assign CKSUM = RESET ? 16'h0000 : cksum_q;
`else
    assign CKSUM = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_port_arb.sv
// Directed bench for rom_port_arb with a behavioural ROM RAM (read latency 1).
// Checksum expectations follow ROM_PORT_ARB_CKSUM_EN.
module tb_rom_port_arb;

    localparam int AW = 17;

`ifdef ROM_PORT_ARB_CKSUM_EN
    localparam logic [15:0] EXP_CK_FIRST  = 16'h0006;
    localparam logic [15:0] EXP_CK_SECOND = 16'h0010;
`else
    localparam logic [15:0] EXP_CK_FIRST  = 16'h0000;
    localparam logic [15:0] EXP_CK_SECOND = 16'h0000;
`endif

    logic          MCLK = 1'b0;
    logic          RESET;
    logic          DL_ACT, DL_WR;
    logic [AW-1:0] DL_AD;
    logic [7:0]    DL_DT;
    logic          CPU_REQ, VID_REQ;
    logic [15:0]   CPU_AD, VID_AD;
    logic          CPU_ACK, VID_ACK;
    logic [7:0]    CPU_DT, VID_DT;
    logic [AW-1:0] MEM_AD;
    logic          MEM_WE;
    logic [7:0]    MEM_DI;
    logic [7:0]    MEM_DO;
    logic          CORE_RST;
    logic [15:0]   CKSUM;

    int checks = 0;
    int errors = 0;
    int n;
    int acks;

    logic [7:0] mem [0:(1<<AW)-1];

    rom_port_arb #(.AW(AW), .VID_BASE(17'h10000), .HOLD(16)) dut (
        .MCLK(MCLK), .RESET(RESET),
        .DL_ACT(DL_ACT), .DL_WR(DL_WR), .DL_AD(DL_AD), .DL_DT(DL_DT),
        .CPU_REQ(CPU_REQ), .CPU_AD(CPU_AD), .CPU_ACK(CPU_ACK), .CPU_DT(CPU_DT),
        .VID_REQ(VID_REQ), .VID_AD(VID_AD), .VID_ACK(VID_ACK), .VID_DT(VID_DT),
        .MEM_AD(MEM_AD), .MEM_WE(MEM_WE), .MEM_DI(MEM_DI), .MEM_DO(MEM_DO),
        .CORE_RST(CORE_RST), .CKSUM(CKSUM)
    );

    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) begin
        if (MEM_WE) mem[MEM_AD] <= MEM_DI;
        MEM_DO <= mem[MEM_AD];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Contents: mem[a] = a[7:0] ^ 8'h5A, with 8'hA5 planted at 17'h01234.
        for (int i = 0; i < (1 << AW); i++) begin
            logic [AW-1:0] a;
            a = AW'(i);
            mem[i] = a[7:0] ^ 8'h5A;
        end
        mem[17'h01234] = 8'hA5;

        RESET = 1'b1; DL_ACT = 1'b0; DL_WR = 1'b0; DL_AD = '0; DL_DT = 8'h00;
        CPU_REQ = 1'b0; CPU_AD = 16'h0000; VID_REQ = 1'b0; VID_AD = 16'h0000;

        repeat (3) @(posedge MCLK);
        @(negedge MCLK);
        chk("rst_core_rst", CORE_RST, 1);
        chk("rst_mem_ad", MEM_AD, 0);
        chk("rst_mem_we", MEM_WE, 0);
        chk("rst_mem_di", MEM_DI, 0);
        chk("rst_acks", {CPU_ACK, VID_ACK}, 0);
        chk("rst_dt", {CPU_DT, VID_DT}, 0);
        chk("rst_cksum", CKSUM, 0);

        // Release reset; a CPU request raised and dropped during the hold is discarded.
        @(posedge MCLK); #1;
        RESET = 1'b0;
        CPU_REQ = 1'b1; CPU_AD = 16'h0042;
        n = 0; acks = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge MCLK);
            if (k == 2) CPU_REQ = 1'b0;
            if (CPU_ACK || VID_ACK) acks++;
            if (CORE_RST) n++;
            else break;
        end
        chk("rst_hold_len", n, 16);
        repeat (3) begin
            @(negedge MCLK);
            if (CPU_ACK || VID_ACK) acks++;
        end
        chk("rst_no_ack", acks, 0);

        // Both channels held for 8 cycles: CPU, VID, CPU, VID.
        CPU_AD = 16'h0042; VID_AD = 16'h0177;
        CPU_REQ = 1'b1; VID_REQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge MCLK);
            if (k[0] == 1'b0) chk("rr_gnt_ad_cpu", MEM_AD, 17'h00042);
            else              chk("rr_gnt_ad_vid", MEM_AD, 17'h10177);
            chk("rr_gnt_we", MEM_WE, 0);
            chk("rr_gnt_noack", {CPU_ACK, VID_ACK}, 0);
            @(negedge MCLK);
            if (k[0] == 1'b0) begin
                chk("rr_ack_cpu", {CPU_ACK, VID_ACK}, 2'b10);
                chk("rr_dt_cpu", CPU_DT, 8'h18);
            end else begin
                chk("rr_ack_vid", {CPU_ACK, VID_ACK}, 2'b01);
                chk("rr_dt_vid", VID_DT, 8'h2D);
            end
        end
        CPU_REQ = 1'b0; VID_REQ = 1'b0;
        @(negedge MCLK);
        chk("hold_acks", {CPU_ACK, VID_ACK}, 0);
        chk("hold_dt", {CPU_DT, VID_DT}, 16'h182D);

        // Download strobe without DL_ACT never writes.
        DL_WR = 1'b1; DL_AD = 17'h00005; DL_DT = 8'hEE;
        @(negedge MCLK);
        chk("dlwr_ignored", MEM_WE, 0);
        chk("dlwr_no_core_rst", CORE_RST, 0);
        DL_WR = 1'b0;
        @(negedge MCLK);

        // Single CPU read of 16'h1234.
        CPU_AD = 16'h1234; CPU_REQ = 1'b1;
        @(negedge MCLK);
        chk("cpu_gnt_ad", MEM_AD, 17'h01234);
        chk("cpu_gnt_we", MEM_WE, 0);
        chk("cpu_gnt_noack", CPU_ACK, 0);
        @(negedge MCLK);
        chk("cpu_ack", {CPU_ACK, VID_ACK}, 2'b10);
        chk("cpu_dt", CPU_DT, 8'hA5);
        CPU_REQ = 1'b0;
        @(negedge MCLK);
        chk("cpu_ack_once", CPU_ACK, 0);
        chk("cpu_dt_hold", CPU_DT, 8'hA5);

        // Download starts during a video grant; the video ACK still arrives.
        VID_AD = 16'h0010; VID_REQ = 1'b1;
        @(posedge MCLK); #1;
        DL_ACT = 1'b1;
        @(negedge MCLK);
        chk("dl_vid_gnt_ad", MEM_AD, 17'h10010);
        chk("dl_vid_gnt_noack", VID_ACK, 0);
        @(negedge MCLK);
        chk("dl_vid_ack", {CPU_ACK, VID_ACK}, 2'b01);
        chk("dl_vid_dt", VID_DT, 8'h4A);
        chk("dl_core_rst", CORE_RST, 1);
        VID_REQ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge MCLK); #1;
            DL_WR = 1'b1; DL_AD = AW'(k); DL_DT = 8'(k + 1);
            @(negedge MCLK);
            chk("dl_we", MEM_WE, 1);
            chk("dl_ad", MEM_AD, k);
            chk("dl_di", MEM_DI, k + 1);
            chk("dl_noack", {CPU_ACK, VID_ACK}, 0);
        end
        @(posedge MCLK); #1;
        DL_WR = 1'b0;
        @(negedge MCLK);
        chk("dl_we_off", MEM_WE, 0);
        chk("dl_cksum", CKSUM, EXP_CK_FIRST);

        // DL_ACT falls, POST runs 5 cycles, then DL_ACT rises again.
        DL_ACT = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge MCLK);
            if (CORE_RST) n++;
            if (CPU_ACK || VID_ACK) n = n + 100;
        end
        chk("post_core_rst_5", n, 5);
        DL_ACT = 1'b1;
        @(negedge MCLK);
        chk("reload_core_rst", CORE_RST, 1);
        @(posedge MCLK); #1;
        DL_WR = 1'b1; DL_AD = 17'h00003; DL_DT = 8'h10;
        @(negedge MCLK);
        chk("reload_we", MEM_WE, 1);
        chk("reload_core_rst2", CORE_RST, 1);
        @(posedge MCLK); #1;
        DL_WR = 1'b0;
        @(negedge MCLK);
        chk("reload_cksum", CKSUM, EXP_CK_SECOND);

        // Final fall: CORE_RST drops 16 cycles after DL_ACT is sampled low.
        @(posedge MCLK); #1;
        DL_ACT = 1'b0;
        @(negedge MCLK);
        chk("fall_load_core_rst", CORE_RST, 1);
        n = 0; acks = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge MCLK);
            if (CPU_ACK || VID_ACK) acks++;
            if (CORE_RST) n++;
            else break;
        end
        chk("fall_hold_len", n, 16);
        chk("fall_no_ack", acks, 0);

        // Reset during a grant aborts it with no ACK.
        CPU_AD = 16'h0042; CPU_REQ = 1'b1;
        @(posedge MCLK); #1;
        RESET = 1'b1;
        @(negedge MCLK);
        chk("abort_ack1", CPU_ACK, 0);
        chk("abort_mem_ad", MEM_AD, 0);
        @(negedge MCLK);
        chk("abort_ack2", {CPU_ACK, VID_ACK}, 0);
        chk("abort_core_rst", CORE_RST, 1);
        chk("abort_dt", CPU_DT, 0);
        CPU_REQ = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
